xc_malu_mul_seq: RTL and testbench

- Self-contained, parametrised, iterative multiplier for the MALU.
- Owns its own state: operand, accumulator and step counter registers, a control FSM and a valid/ready handshake. Callers therefore no longer hold that state.
- Retires BITS_PER_STEP multiplier bits per cycle.
- Supports mul, mulh, mulhsu, mulhu, clmul and clmulh at any even XLEN.
- Sits beside the packed adder inside the MALU, driven by the decode stage.

---
 rtl/xc_malu_mul_seq.sv | 159 +++++++++++++++
 tb/tb_xc_malu_mul_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xc_malu_mul_seq.sv
// Iterative shift-add / carry-less multiplier for the MALU, BITS_PER_STEP bits per cycle.
// Define XC_MALU_MUL_CLMULR_EN to enable clmulr on op 6 (otherwise op 6 is reserved).
module xc_malu_mul_seq #(
  parameter int XLEN          = 32,
  parameter int BITS_PER_STEP = 1
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            valid,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            ready,
  output logic [XLEN-1:0] result
);

  localparam int N  = XLEN / BITS_PER_STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = 2 * XLEN + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN:0]   md_q, md_d;
  logic [XLEN-1:0] mr_q, mr_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            in_s1;
  logic            q_s2;
  logic            q_cl;
  logic [AW-1:0]   step_acc;
  logic [XLEN+1:0] sum;
  logic [XLEN+1:0] addend;
  logic [XLEN-1:0] res_sel;

  // Multiplicand is sign-extended at capture for mulh / mulhsu.
  always_comb begin
    in_s1 = 1'b0;
    case (op)
      3'd1, 3'd2: in_s1 = 1'b1;
      default:    in_s1 = 1'b0;
    endcase
  end

  always_comb begin
    q_s2 = 1'b0;
    q_cl = 1'b0;
    case (op_q)
      3'd1:       q_s2 = 1'b1;
      3'd4, 3'd5: q_cl = 1'b1;
`ifdef XC_MALU_MUL_CLMULR_EN
      3'd6:       q_cl = 1'b1;
`endif
      default: begin
        q_s2 = 1'b0;
        q_cl = 1'b0;
      end
    endcase
  end

  // Upper half is widened by one bit so the add cannot overflow before the shift.
  always_comb begin
    step_acc = acc_q;
    sum      = '0;
    addend   = {md_q[XLEN], md_q};
    for (int b = 0; b < BITS_PER_STEP; b++) begin
      sum = {step_acc[AW-1], step_acc[AW-1:XLEN]};
      if (mr_q[b]) begin
        if (q_cl) begin
          sum = sum ^ addend;
        end else if (q_s2 && (cnt_q == LAST) && (b == BITS_PER_STEP - 1)) begin
          sum = sum - addend;
        end else begin
          sum = sum + addend;
        end
      end
      step_acc = {sum, step_acc[XLEN-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    md_d    = md_q;
    mr_d    = mr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (valid && !flush) begin
          state_d = S_BUSY;
          op_d    = op;
          md_d    = {in_s1 & rs1[XLEN-1], rs1};
          mr_d    = rs2;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_acc;
          mr_d  = mr_q >> BITS_PER_STEP;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    res_sel = '0;
    case (op_q)
      3'd0, 3'd4:             res_sel = acc_q[XLEN-1:0];
      3'd1, 3'd2, 3'd3, 3'd5: res_sel = acc_q[2*XLEN-1:XLEN];
`ifdef XC_MALU_MUL_CLMULR_EN
      3'd6:                   res_sel = acc_q[2*XLEN-2:XLEN-1];
`endif
      default:                res_sel = '0;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      md_q    <= '0;
      mr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      md_q    <= md_d;
      mr_q    <= mr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign ready  = (state_q == S_DONE) && !flush && !g_reset;
  assign result = ready ? res_sel : '0;

endmodule

// File: tb/tb_xc_malu_mul_seq.sv
// Directed-vector and random bench for xc_malu_mul_seq at (32,1), (32,4), (16,2).
// Expected values come from hand-computed tables and a wide-integer reference model.
module tb_xc_malu_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        va, vb, vc;
  logic        busy_a, ready_a, busy_b, ready_b, busy_c, ready_c;
  logic [31:0] res_a, res_b;
  logic [15:0] res_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xc_malu_mul_seq #(.XLEN(32), .BITS_PER_STEP(1)) u_a (
    .g_clk(clk), .g_reset(rst), .valid(va), .flush(flush), .op(op_i),
    .rs1(rs1_i), .rs2(rs2_i), .busy(busy_a), .ready(ready_a), .result(res_a)
  );

  xc_malu_mul_seq #(.XLEN(32), .BITS_PER_STEP(4)) u_b (
    .g_clk(clk), .g_reset(rst), .valid(vb), .flush(flush), .op(op_i),
    .rs1(rs1_i), .rs2(rs2_i), .busy(busy_b), .ready(ready_b), .result(res_b)
  );

  xc_malu_mul_seq #(.XLEN(16), .BITS_PER_STEP(2)) u_c (
    .g_clk(clk), .g_reset(rst), .valid(vc), .flush(flush), .op(op_i),
    .rs1(rs1_i[15:0]), .rs2(rs2_i[15:0]), .busy(busy_c), .ready(ready_c),
    .result(res_c)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tv [14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o,
                                        input logic [31:0] x,
                                        input logic [31:0] y,
                                        input int xl);
    logic [127:0] m, ux, uy, p, c, r;
    logic signed [127:0] sx, sy;
    m  = (128'd1 << xl) - 128'd1;
    ux = {96'd0, x} & m;
    uy = {96'd0, y} & m;
    sx = x[xl-1] ? $signed(ux) - $signed(128'd1 << xl) : $signed(ux);
    sy = y[xl-1] ? $signed(uy) - $signed(128'd1 << xl) : $signed(uy);
    c  = '0;
    for (int i = 0; i < xl; i++) begin
      if (uy[i]) c = c ^ (ux << i);
    end
    p = '0;
    r = '0;
    case (o)
      3'd0: begin p = ux * uy; r = p & m; end
      3'd1: begin p = sx * sy; r = (p >> xl) & m; end
      3'd2: begin p = sx * $signed(uy); r = (p >> xl) & m; end
      3'd3: begin p = ux * uy; r = (p >> xl) & m; end
      3'd4: r = c & m;
      3'd5: r = (c >> xl) & m;
`ifdef XC_MALU_MUL_CLMULR_EN
      3'd6: r = (c >> (xl - 1)) & m;
`endif
      default: r = '0;
    endcase
    return r[31:0];
  endfunction

  task automatic run_all(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit pert,
                         output logic [31:0] ra, output logic [31:0] rb,
                         output logic [31:0] rc, output int la,
                         output int lb, output int lc,
                         output logic [31:0] after);
    ra = '0; rb = '0; rc = '0;
    la = 0;  lb = 0;  lc = 0;
    @(negedge clk);
    op_i = o; rs1_i = x; rs2_i = y;
    va = 1'b1; vb = 1'b1; vc = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (va && ready_a) begin ra = res_a; la = i; va = 1'b0; end
      if (vb && ready_b) begin rb = res_b; lb = i; vb = 1'b0; end
      if (vc && ready_c) begin rc = {16'd0, res_c}; lc = i; vc = 1'b0; end
      if (pert && i == 2) begin
        op_i  = 3'($urandom_range(0, 7));
        rs1_i = $urandom;
        rs2_i = $urandom;
      end
      if (!va && !vb && !vc) break;
    end
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    @(negedge clk);
    after = {26'd0, ready_a, ready_b, ready_c, busy_a, busy_b, busy_c};
  endtask

  task automatic check_run(input string nm, input logic [2:0] o,
                           input logic [31:0] x, input logic [31:0] y,
                           input bit pert, input logic [31:0] exp32);
    logic [31:0] ra, rb, rc, after;
    int la, lb, lc;
    run_all(o, x, y, pert, ra, rb, rc, la, lb, lc, after);
    chk({nm, "_res_a"}, ra, exp32);
    chk({nm, "_res_b"}, rb, exp32);
    chk({nm, "_res_c"}, rc, model(o, x, y, 16));
    chk({nm, "_lat_a"}, la, 32'd33);
    chk({nm, "_lat_b"}, lb, 32'd9);
    chk({nm, "_lat_c"}, lc, 32'd9);
    chk({nm, "_idle_after"}, after, 32'd0);
  endtask

  task automatic wait_a(output int lat, output logic [31:0] r);
    lat = 0;
    r   = '0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (ready_a) begin
        lat = i;
        r   = res_a;
        va  = 1'b0;
        break;
      end
    end
    va = 1'b0;
  endtask

  function automatic logic [31:0] pick(input int k);
    logic [31:0] v;
    case (k)
      0:       v = 32'h0000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_8000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] e6, r;
    logic [31:0] x, y;
    logic [2:0]  o;
    int          lat;
    bit          seen;

`ifdef XC_MALU_MUL_CLMULR_EN
    e6 = 32'h8000_0000;
`else
    e6 = 32'h0000_0000;
`endif
    tv[0]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    tv[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tv[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    tv[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tv[4]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    tv[5]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    tv[6]  = '{3'd4, 32'h0000_0003, 32'h0000_0003, 32'h0000_0005};
    tv[7]  = '{3'd5, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    tv[8]  = '{3'd6, 32'h8000_0000, 32'h8000_0000, e6};
    tv[9]  = '{3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000};
    tv[10] = '{3'd0, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
    tv[11] = '{3'd0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    tv[12] = '{3'd3, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    tv[13] = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE};

    rst = 1'b1; flush = 1'b0;
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    op_i = '0; rs1_i = '0; rs2_i = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {29'd0, busy_a, busy_b, busy_c}, 32'd0);
    chk("reset_ready", {29'd0, ready_a, ready_b, ready_c}, 32'd0);
    chk("reset_result", res_a | res_b | {16'd0, res_c}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      check_run($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].b, 1'b0,
                tv[i].exp);
    end

    // Flush during step 10: no ready, busy gone the next cycle.
    @(negedge clk);
    op_i = 3'd0; rs1_i = 32'h1234; rs2_i = 32'h5678; va = 1'b1;
    @(posedge clk);
    repeat (10) @(negedge clk);
    chk("flush_pre_busy", {31'd0, busy_a}, 32'd1);
    flush = 1'b1; va = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_drop", {31'd0, busy_a}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready_a) seen = 1'b1;
    end
    chk("flush_no_ready", {31'd0, seen}, 32'd0);
    check_run("post_flush", 3'd0, 32'd7, 32'd6, 1'b0, 32'd42);

    // Flush in the DONE cycle masks ready.
    @(negedge clk);
    op_i = 3'd0; rs1_i = 32'd5; rs2_i = 32'd3; va = 1'b1;
    @(posedge clk);
    repeat (33) @(negedge clk);
    va = 1'b0;
    chk("done_ready_pre", {31'd0, ready_a}, 32'd1);
    flush = 1'b1;
    #1;
    chk("done_flush_ready", {31'd0, ready_a}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("done_flush_idle", {31'd0, busy_a}, 32'd0);

    // Flush with valid in IDLE is not an accept.
    flush = 1'b1; va = 1'b1;
    op_i = 3'd0; rs1_i = 32'd9; rs2_i = 32'd9;
    repeat (3) @(negedge clk);
    chk("idle_flush_noaccept", {31'd0, busy_a}, 32'd0);
    flush = 1'b0;
    wait_a(lat, r);
    chk("idle_flush_lat", lat, 32'd33);
    chk("idle_flush_res", r, 32'd81);

    // Reset mid-operation, then reset with valid held high.
    @(negedge clk);
    op_i = 3'd3; rs1_i = 32'hFFFF_FFFF; rs2_i = 32'hFFFF_FFFF; va = 1'b1;
    @(posedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_mid_ready", {31'd0, ready_a}, 32'd0);
    chk("rst_mid_result", res_a, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_valid_noaccept", {31'd0, busy_a}, 32'd0);
    rst = 1'b0;
    wait_a(lat, r);
    chk("rst_release_lat", lat, 32'd33);
    chk("rst_release_res", r, 32'hFFFF_FFFE);

    // Random ops; odd iterations scramble the inputs while busy.
    for (int n = 0; n < 150; n++) begin
      o = 3'($urandom_range(0, 7));
      x = pick($urandom_range(0, 4));
      y = pick($urandom_range(0, 4));
      check_run($sformatf("rnd%0d", n), o, x, y, n[0], model(o, x, y, 32));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
